// File: rtl/mem_dump_reader.sv
// rtl/mem_dump_reader.sv - sequential read-only memory dump streamed to a ready/valid sink
module mem_dump_reader #(
  parameter logic [31:0] BASE_ADDR   = 32'h0,
  parameter int          NUM_WORDS   = 512,
  parameter int          MEM_LATENCY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        mem_en,
  output logic [31:0] mem_addr,
  input  logic [31:0] mem_rdata,
  output logic [31:0] dout,
  output logic        dout_valid,
  input  logic        dout_ready,
  output logic        dout_last,
  output logic        busy,
  output logic        done
);

  typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD, S_DONE} state_t;

  localparam logic [16:0] LAST_IDX = 17'(NUM_WORDS - 1);
  localparam logic [3:0]  LAT      = 4'(MEM_LATENCY);

  state_t      state, state_nxt;
  logic [16:0] count, count_nxt;
  logic [3:0]  lat_cnt, lat_nxt;
  logic [31:0] dout_nxt;
  logic [31:0] cur_addr;

  // 32-bit add, so the address wraps past 32'hFFFF_FFFF naturally
  assign cur_addr = BASE_ADDR + {15'd0, count};

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      count   <= '0;
      lat_cnt <= '0;
      dout    <= '0;
    end else begin
      state   <= state_nxt;
      count   <= count_nxt;
      lat_cnt <= lat_nxt;
      dout    <= dout_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    count_nxt  = count;
    lat_nxt    = lat_cnt;
    dout_nxt   = dout;
    mem_en     = 1'b0;
    mem_addr   = '0;
    dout_valid = 1'b0;
    dout_last  = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        done = (state == S_DONE);
        if (start) begin
          state_nxt = S_REQ;
          count_nxt = '0;
        end
      end
      S_REQ: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = cur_addr;
        lat_nxt   = LAT;
        state_nxt = S_WAIT;
      end
      S_WAIT: begin
        busy     = 1'b1;
        mem_addr = cur_addr;
        lat_nxt  = lat_cnt - 4'd1;
        // lat_cnt reaching 1 marks the cycle in which mem_rdata is valid
        if (lat_cnt == 4'd1) begin
          dout_nxt  = mem_rdata;
          state_nxt = S_HOLD;
        end
      end
      S_HOLD: begin
        busy       = 1'b1;
        mem_addr   = cur_addr;
        dout_valid = 1'b1;
        dout_last  = (count == LAST_IDX);
        if (dout_ready) begin
          if (count == LAST_IDX) begin
            state_nxt = S_DONE;
          end else begin
            count_nxt = count + 17'd1;
            state_nxt = S_REQ;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_dump_reader.sv
// tb/tb_mem_dump_reader.sv - self-checking bench for mem_dump_reader
module tb_mem_dump_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  localparam logic [31:0] C_BASE = 32'hFFFF_FFFE;
  localparam int          C_N    = 5;

  // instance A: BASE=0x10, N=4, L=1
  logic        a_rst = 1'b1, a_start = 1'b0, a_ready = 1'b0;
  logic        a_en, a_valid, a_last, a_busy, a_done;
  logic [31:0] a_addr, a_rdata, a_dout;
  // instance B: BASE=0x10, N=1, L=3
  logic        b_rst = 1'b1, b_start = 1'b0, b_ready = 1'b0;
  logic        b_en, b_valid, b_last, b_busy, b_done;
  logic [31:0] b_addr, b_rdata, b_dout;
  // instance C: wrapping base, N=5, L=2
  logic        c_rst = 1'b1, c_start = 1'b0, c_ready = 1'b0;
  logic        c_en, c_valid, c_last, c_busy, c_done;
  logic [31:0] c_addr, c_rdata, c_dout;

  mem_dump_reader #(.BASE_ADDR(32'h10), .NUM_WORDS(4), .MEM_LATENCY(1)) dut_a (
    .clk(clk), .rst(a_rst), .start(a_start), .mem_en(a_en), .mem_addr(a_addr),
    .mem_rdata(a_rdata), .dout(a_dout), .dout_valid(a_valid), .dout_ready(a_ready),
    .dout_last(a_last), .busy(a_busy), .done(a_done));

  mem_dump_reader #(.BASE_ADDR(32'h10), .NUM_WORDS(1), .MEM_LATENCY(3)) dut_b (
    .clk(clk), .rst(b_rst), .start(b_start), .mem_en(b_en), .mem_addr(b_addr),
    .mem_rdata(b_rdata), .dout(b_dout), .dout_valid(b_valid), .dout_ready(b_ready),
    .dout_last(b_last), .busy(b_busy), .done(b_done));

  mem_dump_reader #(.BASE_ADDR(C_BASE), .NUM_WORDS(C_N), .MEM_LATENCY(2)) dut_c (
    .clk(clk), .rst(c_rst), .start(c_start), .mem_en(c_en), .mem_addr(c_addr),
    .mem_rdata(c_rdata), .dout(c_dout), .dout_valid(c_valid), .dout_ready(c_ready),
    .dout_last(c_last), .busy(c_busy), .done(c_done));

  // Memories: word at address x holds 0xA000_0000+x, valid exactly L cycles after mem_en, garbage otherwise
  logic [31:0] a_pa[8], b_pa[8], c_pa[8];
  logic [7:0]  a_pv = '0, b_pv = '0, c_pv = '0;
  always @(posedge clk) begin
    a_pv <= {a_pv[6:0], a_en};
    b_pv <= {b_pv[6:0], b_en};
    c_pv <= {c_pv[6:0], c_en};
    a_pa[0] <= a_addr;
    b_pa[0] <= b_addr;
    c_pa[0] <= c_addr;
    for (int i = 1; i < 8; i++) begin
      a_pa[i] <= a_pa[i-1];
      b_pa[i] <= b_pa[i-1];
      c_pa[i] <= c_pa[i-1];
    end
  end
  assign a_rdata = a_pv[0] ? 32'hA000_0000 + a_pa[0] : 32'hDEAD_BEEF;
  assign b_rdata = b_pv[2] ? 32'hA000_0000 + b_pa[2] : 32'hDEAD_BEEF;
  assign c_rdata = c_pv[1] ? 32'hA000_0000 + c_pa[1] : 32'hDEAD_BEEF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    a_rst = 1'b1; b_rst = 1'b1; c_rst = 1'b1;
    a_start = 1'b1; b_start = 1'b1; c_start = 1'b1;
    step();
    step();
    total++;
    if ({a_en, a_addr, a_dout, a_valid, a_last, a_busy, a_done} !== '0) begin
      bad++;
      $display("FAIL reset_outputs got en=%0b addr=%h dout=%h v=%0b l=%0b busy=%0b done=%0b want all 0",
               a_en, a_addr, a_dout, a_valid, a_last, a_busy, a_done);
    end
    a_rst = 1'b0; b_rst = 1'b0; c_rst = 1'b0;
    a_start = 1'b0; b_start = 1'b0; c_start = 1'b0;
    step();
    total++;
    if (a_busy !== 1'b0 || a_en !== 1'b0) begin
      bad++;
      $display("FAIL reset_start_ignored got busy=%0b en=%0b want 0 0", a_busy, a_en);
    end
  endtask

  // Runs one dump with ready high from cycle 0 and checks cycle-exact timing; extra start at pulse_cycle
  task automatic timed_dump(input int pulse_cycle);
    logic        exp_en, exp_valid, exp_done, exp_last;
    logic [31:0] exp_addr, exp_dout;
    a_ready = 1'b1;
    for (int c = 0; c <= 14; c++) begin
      a_start = (c == 0) || (c == pulse_cycle);
      if (c >= 1) begin
        exp_en    = (c <= 10) && ((c - 1) % 3 == 0);
        exp_valid = (c >= 3) && (c <= 12) && (c % 3 == 0);
        exp_last  = (c == 12);
        exp_done  = (c >= 13);
        exp_addr  = 32'h10 + 32'((c - 1) / 3);
        exp_dout  = 32'hA000_0010 + 32'((c - 3) / 3);
        total++;
        if (a_en !== exp_en) begin
          bad++; $display("FAIL dump_en cycle %0d got %0b want %0b", c, a_en, exp_en);
        end
        if (exp_en) begin
          total++;
          if (a_addr !== exp_addr) begin
            bad++; $display("FAIL dump_addr cycle %0d got %h want %h", c, a_addr, exp_addr);
          end
        end
        total++;
        if (a_valid !== exp_valid) begin
          bad++; $display("FAIL dump_valid cycle %0d got %0b want %0b", c, a_valid, exp_valid);
        end
        if (exp_valid) begin
          total++;
          if (a_dout !== exp_dout) begin
            bad++; $display("FAIL dump_dout cycle %0d got %h want %h", c, a_dout, exp_dout);
          end
        end
        total++;
        if (a_last !== exp_last) begin
          bad++; $display("FAIL dump_last cycle %0d got %0b want %0b", c, a_last, exp_last);
        end
        total++;
        if (a_done !== exp_done) begin
          bad++; $display("FAIL dump_done cycle %0d got %0b want %0b", c, a_done, exp_done);
        end
      end
      step();
    end
    a_start = 1'b0;
  endtask

  task automatic test_dump();
    timed_dump(-1);
  endtask

  task automatic test_restart();
    timed_dump(5);
  endtask

  task automatic test_backpressure();
    logic [31:0] got[$];
    int stall = 0;
    int cyc = 0;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    while (!a_done && cyc < 100) begin
      if (a_valid && got.size() == 1 && stall < 5) begin
        a_ready = 1'b0;
        stall++;
        total++;
        if (a_dout !== 32'hA000_0011 || a_en !== 1'b0) begin
          bad++;
          $display("FAIL stall_hold got dout=%h en=%0b want A0000011 0", a_dout, a_en);
        end
      end else begin
        a_ready = 1'b1;
      end
      if (a_valid && a_ready) got.push_back(a_dout);
      step();
      cyc++;
    end
    total++;
    if (!a_done) begin
      bad++; $display("FAIL stall_timeout got done=0 want done=1");
    end
    total++;
    if (got.size() != 4 || stall != 5) begin
      bad++; $display("FAIL stall_count got words=%0d stalls=%0d want 4 5", got.size(), stall);
    end
    for (int i = 0; i < got.size() && i < 4; i++) begin
      total++;
      if (got[i] !== 32'hA000_0010 + 32'(i)) begin
        bad++; $display("FAIL stall_word %0d got %h want %h", i, got[i], 32'hA000_0010 + 32'(i));
      end
    end
  endtask

  task automatic test_reset_mid();
    int hs = 0;
    int cyc = 0;
    a_ready = 1'b1;
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    while (!(a_valid && hs == 2) && cyc < 100) begin
      if (a_valid) hs++;
      step();
      cyc++;
    end
    total++;
    if (a_dout !== 32'hA000_0012) begin
      bad++; $display("FAIL midrst_held got %h want A0000012", a_dout);
    end
    a_ready = 1'b0;
    a_rst = 1'b1;
    a_start = 1'b1;
    step();
    a_rst = 1'b0;
    a_start = 1'b0;
    total++;
    if ({a_en, a_addr, a_dout, a_valid, a_last, a_busy, a_done} !== '0) begin
      bad++;
      $display("FAIL midrst_zero got en=%0b addr=%h dout=%h v=%0b busy=%0b done=%0b want all 0",
               a_en, a_addr, a_dout, a_valid, a_busy, a_done);
    end
    a_start = 1'b1;
    step();
    a_start = 1'b0;
    total++;
    if (a_en !== 1'b1 || a_addr !== 32'h10) begin
      bad++; $display("FAIL midrst_restart got en=%0b addr=%h want 1 00000010", a_en, a_addr);
    end
    a_ready = 1'b1;
    cyc = 0;
    while (!a_done && cyc < 100) begin
      step();
      cyc++;
    end
    total++;
    if (!a_done) begin
      bad++; $display("FAIL midrst_timeout got done=0 want done=1");
    end
  endtask

  task automatic test_latency3();
    b_ready = 1'b1;
    b_start = 1'b1;
    step();
    b_start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      total++;
      if (b_en !== (c == 1) || b_valid !== (c == 5) || b_done !== (c >= 6)) begin
        bad++;
        $display("FAIL lat3_timing cycle %0d got en=%0b v=%0b done=%0b want %0b %0b %0b",
                 c, b_en, b_valid, b_done, c == 1, c == 5, c >= 6);
      end
      if (c == 5) begin
        total++;
        if (b_dout !== 32'hA000_0010 || b_last !== 1'b1) begin
          bad++; $display("FAIL lat3_word got %h last=%0b want A0000010 1", b_dout, b_last);
        end
      end
      step();
    end
  endtask

  // Random ready and stray starts; the model is the list of addresses BASE+i mod 2^32
  task automatic test_wrap_random();
    for (int d = 0; d < 3; d++) begin
      int idx = 0;
      int reads = 0;
      int cyc = 0;
      logic [31:0] exp_addr;
      repeat ($urandom_range(0, 3)) step();
      c_start = 1'b1;
      step();
      while (!c_done && cyc < 500) begin
        c_start = ($urandom_range(0, 7) == 0);
        c_ready = $urandom_range(0, 1) != 0;
        exp_addr = C_BASE + 32'(idx);
        if (c_en) begin
          reads++;
          total++;
          if (c_addr !== exp_addr || c_valid !== 1'b0) begin
            bad++; $display("FAIL wrap_read dump %0d got %h v=%0b want %h 0", d, c_addr, c_valid, exp_addr);
          end
        end
        if (c_valid && c_ready) begin
          total++;
          if (c_dout !== 32'hA000_0000 + exp_addr || c_last !== (idx == C_N - 1)) begin
            bad++;
            $display("FAIL wrap_word dump %0d idx %0d got %h last=%0b want %h %0b",
                     d, idx, c_dout, c_last, 32'hA000_0000 + exp_addr, idx == C_N - 1);
          end
          idx++;
        end
        step();
        cyc++;
      end
      c_start = 1'b0;
      total++;
      if (!c_done || idx != C_N || reads != C_N) begin
        bad++;
        $display("FAIL wrap_end dump %0d got done=%0b words=%0d reads=%0d want 1 %0d %0d",
                 d, c_done, idx, reads, C_N, C_N);
      end
    end
  endtask

  initial begin
    test_reset();
    test_dump();
    test_restart();
    test_backpressure();
    test_reset_mid();
    test_latency3();
    test_wrap_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
